// File: rtl/fp_align_stage_if.sv
// Handshake and data bundle between the operand source, the align stage
// and the add/normalise stage downstream.
interface fp_align_stage_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int WIDTH = 1 + EXP_W + MAN_W
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic               out_sign_big;
  logic               out_sign_small;
  logic [EXP_W-1:0]   out_exp;
  logic [MAN_W+3:0]   out_man_big;
  logic [MAN_W+3:0]   out_man_small;
  logic               out_swap;
  logic               out_special;

  // Operand source and result sink side
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out_sign_big, out_sign_small, out_exp,
           out_man_big, out_man_small, out_swap, out_special
  );

  // Align stage side
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out_sign_big, out_sign_small, out_exp,
           out_man_big, out_man_small, out_swap, out_special
  );
endinterface

// File: rtl/fp_align_stage.sv
// Two-stage unpack/align stage for the single-precision adder.
// Stage 1 unpacks both operands, orders them by magnitude and forms the
// exponent difference; stage 2 right-shifts the smaller significand with
// guard/round/sticky. Each stage is simply empty or full.
module fp_align_stage #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic                clk,
  input  logic                rst,
  fp_align_stage_if.slave     bus
);
  localparam int SIG_W = MAN_W + 1;
  localparam int EXT_W = MAN_W + 4;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  logic s1_adv, s2_adv;

  logic               s1_valid_q, s1_valid_d;
  logic               s1_sign_big_q, s1_sign_big_d;
  logic               s1_sign_small_q, s1_sign_small_d;
  logic [EXP_W-1:0]   s1_exp_q, s1_exp_d;
  logic [EXP_W-1:0]   s1_diff_q, s1_diff_d;
  logic [SIG_W-1:0]   s1_sig_big_q, s1_sig_big_d;
  logic [SIG_W-1:0]   s1_sig_small_q, s1_sig_small_d;
  logic               s1_swap_q, s1_swap_d;
  logic               s1_special_q, s1_special_d;

  logic               s2_valid_q, s2_valid_d;
  logic               s2_sign_big_q, s2_sign_big_d;
  logic               s2_sign_small_q, s2_sign_small_d;
  logic [EXP_W-1:0]   s2_exp_q, s2_exp_d;
  logic [EXT_W-1:0]   s2_man_big_q, s2_man_big_d;
  logic [EXT_W-1:0]   s2_man_small_q, s2_man_small_d;
  logic               s2_swap_q, s2_swap_d;
  logic               s2_special_q, s2_special_d;

  logic [EXP_W-1:0]   exp_a, exp_b, eff_a, eff_b;
  logic [SIG_W-1:0]   sig_a, sig_b;
  logic               swap;
  logic [EXT_W-1:0]   ext, shifted, lost;
  logic               sticky;

  assign s2_adv       = !s2_valid_q | bus.out_ready;
  assign s1_adv       = !s1_valid_q | s2_adv;
  assign bus.in_ready = s1_adv;

  // Unpack both operands; denormals use effective exponent 1 and no hidden bit
  always_comb begin
    exp_a = bus.a[WIDTH-2 -: EXP_W];
    exp_b = bus.b[WIDTH-2 -: EXP_W];
    sig_a = {(exp_a != '0), bus.a[MAN_W-1:0]};
    sig_b = {(exp_b != '0), bus.b[MAN_W-1:0]};
    eff_a = (exp_a != '0) ? exp_a : EXP_W'(1);
    eff_b = (exp_b != '0) ? exp_b : EXP_W'(1);
    swap  = {eff_b, sig_b} > {eff_a, sig_a};
  end

  // Stage 1 next state: capture the ordered operands on an accepted transfer
  always_comb begin
    s1_valid_d      = s1_valid_q;
    s1_sign_big_d   = s1_sign_big_q;
    s1_sign_small_d = s1_sign_small_q;
    s1_exp_d        = s1_exp_q;
    s1_diff_d       = s1_diff_q;
    s1_sig_big_d    = s1_sig_big_q;
    s1_sig_small_d  = s1_sig_small_q;
    s1_swap_d       = s1_swap_q;
    s1_special_d    = s1_special_q;
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_swap_d       = swap;
        s1_sign_big_d   = swap ? bus.b[WIDTH-1] : bus.a[WIDTH-1];
        s1_sign_small_d = swap ? bus.a[WIDTH-1] : bus.b[WIDTH-1];
        s1_exp_d        = swap ? eff_b : eff_a;
        s1_diff_d       = swap ? (eff_b - eff_a) : (eff_a - eff_b);
        s1_sig_big_d    = swap ? sig_b : sig_a;
        s1_sig_small_d  = swap ? sig_a : sig_b;
        s1_special_d    = (exp_a == EXP_ONES) | (exp_b == EXP_ONES);
      end
    end
  end

  // Alignment shift; anything shifted past bit 0 collapses into sticky
  always_comb begin
    ext = {s1_sig_small_q, 3'b000};
    if (s1_diff_q >= EXP_W'(EXT_W)) begin
      shifted = '0;
      lost    = '0;
      sticky  = |s1_sig_small_q;
    end else begin
      shifted = ext >> s1_diff_q;
      lost    = ext & ~({EXT_W{1'b1}} << s1_diff_q);
      sticky  = |lost;
    end
  end

  // Stage 2 next state: move stage 1 forward when the output slot frees up
  always_comb begin
    s2_valid_d      = s2_valid_q;
    s2_sign_big_d   = s2_sign_big_q;
    s2_sign_small_d = s2_sign_small_q;
    s2_exp_d        = s2_exp_q;
    s2_man_big_d    = s2_man_big_q;
    s2_man_small_d  = s2_man_small_q;
    s2_swap_d       = s2_swap_q;
    s2_special_d    = s2_special_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_big_d   = s1_sign_big_q;
        s2_sign_small_d = s1_sign_small_q;
        s2_exp_d        = s1_exp_q;
        s2_man_big_d    = {s1_sig_big_q, 3'b000};
        s2_man_small_d  = {shifted[EXT_W-1:1], shifted[0] | sticky};
        s2_swap_d       = s1_swap_q;
        s2_special_d    = s1_special_q;
      end
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q      <= 1'b0;
      s1_sign_big_q   <= 1'b0;
      s1_sign_small_q <= 1'b0;
      s1_exp_q        <= '0;
      s1_diff_q       <= '0;
      s1_sig_big_q    <= '0;
      s1_sig_small_q  <= '0;
      s1_swap_q       <= 1'b0;
      s1_special_q    <= 1'b0;
    end else begin
      s1_valid_q      <= s1_valid_d;
      s1_sign_big_q   <= s1_sign_big_d;
      s1_sign_small_q <= s1_sign_small_d;
      s1_exp_q        <= s1_exp_d;
      s1_diff_q       <= s1_diff_d;
      s1_sig_big_q    <= s1_sig_big_d;
      s1_sig_small_q  <= s1_sig_small_d;
      s1_swap_q       <= s1_swap_d;
      s1_special_q    <= s1_special_d;
    end
  end

  // Stage 2 registers, which drive the outputs directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q      <= 1'b0;
      s2_sign_big_q   <= 1'b0;
      s2_sign_small_q <= 1'b0;
      s2_exp_q        <= '0;
      s2_man_big_q    <= '0;
      s2_man_small_q  <= '0;
      s2_swap_q       <= 1'b0;
      s2_special_q    <= 1'b0;
    end else begin
      s2_valid_q      <= s2_valid_d;
      s2_sign_big_q   <= s2_sign_big_d;
      s2_sign_small_q <= s2_sign_small_d;
      s2_exp_q        <= s2_exp_d;
      s2_man_big_q    <= s2_man_big_d;
      s2_man_small_q  <= s2_man_small_d;
      s2_swap_q       <= s2_swap_d;
      s2_special_q    <= s2_special_d;
    end
  end

  assign bus.out_valid      = s2_valid_q;
  assign bus.out_sign_big   = s2_sign_big_q;
  assign bus.out_sign_small = s2_sign_small_q;
  assign bus.out_exp        = s2_exp_q;
  assign bus.out_man_big    = s2_man_big_q;
  assign bus.out_man_small  = s2_man_small_q;
  assign bus.out_swap       = s2_swap_q;
  assign bus.out_special    = s2_special_q;
endmodule

// File: tb/tb_fp_align_stage.sv
// Directed bench for fp_align_stage: hand-computed vectors, backpressure and
// mid-stream reset.
module tb_fp_align_stage;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fp_align_stage_if bus ();

  fp_align_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic        cap_got;
  int          cap_lat;
  logic        cap_sign_big, cap_sign_small, cap_swap, cap_special;
  logic [7:0]  cap_exp;
  logic [26:0] cap_man_big, cap_man_small;

  // Send one pair into an idle pipeline and capture the single result
  task automatic send_one(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    bus.a         = av;
    bus.b         = bv;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    cap_lat = 1;
    cap_got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        cap_got        = 1'b1;
        cap_sign_big   = bus.out_sign_big;
        cap_sign_small = bus.out_sign_small;
        cap_exp        = bus.out_exp;
        cap_man_big    = bus.out_man_big;
        cap_man_small  = bus.out_man_small;
        cap_swap       = bus.out_swap;
        cap_special    = bus.out_special;
        break;
      end
      @(posedge clk);
      cap_lat++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_exp !== 8'd0 || bus.out_man_big !== 27'd0 || bus.out_man_small !== 27'd0) begin errors++; $display("FAIL reset_out_data: got exp %h big %h small %h expected all 0", bus.out_exp, bus.out_man_big, bus.out_man_small); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_equal;
    send_one(32'h3F800000, 32'h3F800000);
    checks++; if (cap_got !== 1'b1) begin errors++; $display("FAIL equal_timeout: got no result expected one"); end
    checks++; if (cap_lat !== 2) begin errors++; $display("FAIL equal_latency: got %0d expected 2", cap_lat); end
    checks++; if (cap_exp !== 8'd127) begin errors++; $display("FAIL equal_exp: got %0d expected 127", cap_exp); end
    checks++; if (cap_man_big !== 27'h4000000) begin errors++; $display("FAIL equal_man_big: got %h expected 4000000", cap_man_big); end
    checks++; if (cap_man_small !== 27'h4000000) begin errors++; $display("FAIL equal_man_small: got %h expected 4000000", cap_man_small); end
    checks++; if (cap_swap !== 1'b0 || cap_special !== 1'b0) begin errors++; $display("FAIL equal_flags: got swap %b special %b expected 0 0", cap_swap, cap_special); end
  endtask

  task automatic test_swap_shift;
    send_one(32'h3F000000, 32'h40000000);
    checks++; if (cap_swap !== 1'b1) begin errors++; $display("FAIL swap_flag: got %b expected 1", cap_swap); end
    checks++; if (cap_exp !== 8'd128) begin errors++; $display("FAIL swap_exp: got %0d expected 128", cap_exp); end
    checks++; if (cap_man_big !== 27'h4000000) begin errors++; $display("FAIL swap_man_big: got %h expected 4000000", cap_man_big); end
    checks++; if (cap_man_small !== 27'h1000000) begin errors++; $display("FAIL swap_man_small: got %h expected 1000000", cap_man_small); end
    send_one(32'hBF000000, 32'h40000000);
    checks++; if (cap_sign_big !== 1'b0 || cap_sign_small !== 1'b1) begin errors++; $display("FAIL swap_signs: got big %b small %b expected 0 1", cap_sign_big, cap_sign_small); end
    send_one(32'h40000000, 32'h3F800000);
    checks++; if (cap_swap !== 1'b0 || cap_man_small !== 27'h2000000) begin errors++; $display("FAIL noswap_shift1: got swap %b small %h expected 0 2000000", cap_swap, cap_man_small); end
  endtask

  task automatic test_sticky;
    send_one(32'h4B800000, 32'h3F800001);
    checks++; if (cap_exp !== 8'd151) begin errors++; $display("FAIL sticky24_exp: got %0d expected 151", cap_exp); end
    checks++; if (cap_man_small !== 27'h0000005) begin errors++; $display("FAIL sticky24_man_small: got %h expected 0000005", cap_man_small); end
    checks++; if (cap_man_big !== 27'h4000000) begin errors++; $display("FAIL sticky24_man_big: got %h expected 4000000", cap_man_big); end
    send_one(32'h4F800000, 32'h3F800000);
    checks++; if (cap_man_small !== 27'h0000001) begin errors++; $display("FAIL sticky_far_man_small: got %h expected 0000001", cap_man_small); end
    checks++; if (cap_exp !== 8'd159) begin errors++; $display("FAIL sticky_far_exp: got %0d expected 159", cap_exp); end
  endtask

  task automatic test_denormal_special;
    send_one(32'h00000001, 32'h00800000);
    checks++; if (cap_swap !== 1'b1 || cap_exp !== 8'd1) begin errors++; $display("FAIL denorm_order: got swap %b exp %0d expected 1 1", cap_swap, cap_exp); end
    checks++; if (cap_man_small !== 27'h0000008) begin errors++; $display("FAIL denorm_man_small: got %h expected 0000008", cap_man_small); end
    checks++; if (cap_man_big !== 27'h4000000) begin errors++; $display("FAIL denorm_man_big: got %h expected 4000000", cap_man_big); end
    send_one(32'h7F800000, 32'h3F800000);
    checks++; if (cap_special !== 1'b1 || cap_exp !== 8'd255) begin errors++; $display("FAIL special_inf: got special %b exp %0d expected 1 255", cap_special, cap_exp); end
    send_one(32'h3F800000, 32'hFFC00000);
    checks++; if (cap_special !== 1'b1 || cap_swap !== 1'b1) begin errors++; $display("FAIL special_nan_b: got special %b swap %b expected 1 1", cap_special, cap_swap); end
    send_one(32'h00000000, 32'h00000000);
    checks++; if (cap_exp !== 8'd1 || cap_swap !== 1'b0) begin errors++; $display("FAIL zero_exp_swap: got exp %0d swap %b expected 1 0", cap_exp, cap_swap); end
    checks++; if (cap_man_big !== 27'd0 || cap_man_small !== 27'd0) begin errors++; $display("FAIL zero_man: got big %h small %h expected 0 0", cap_man_big, cap_man_small); end
  endtask

  task automatic test_backpressure;
    logic [31:0] pa [4];
    logic [31:0] pb [4];
    logic [7:0]  ee [4];
    logic [26:0] es [4];
    int          sent, rcvd;
    logic        ir, ov;
    logic [7:0]  oe;
    logic [26:0] os;
    pa[0] = 32'h3F800000; pb[0] = 32'h3F800000; ee[0] = 8'd127; es[0] = 27'h4000000;
    pa[1] = 32'h3F000000; pb[1] = 32'h40000000; ee[1] = 8'd128; es[1] = 27'h1000000;
    pa[2] = 32'h4B800000; pb[2] = 32'h3F800001; ee[2] = 8'd151; es[2] = 27'h0000005;
    pa[3] = 32'h4F800000; pb[3] = 32'h3F800000; ee[3] = 8'd159; es[3] = 27'h0000001;
    sent = 0;
    rcvd = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.a = pa[sent];
      bus.b = pb[sent];
      bus.in_valid = 1'b1;
      #1 ir = bus.in_ready;
      if (c >= 2) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_exp !== ee[0] || bus.out_man_small !== es[0]) begin errors++; $display("FAIL bp_stall_hold c%0d: got valid %b exp %0d small %h expected 1 %0d %h", c, bus.out_valid, bus.out_exp, bus.out_man_small, ee[0], es[0]); end
      end
      @(posedge clk);
      if (ir) sent++;
    end
    checks++; if (sent !== 2) begin errors++; $display("FAIL bp_accepted_while_stalled: got %0d expected 2", sent); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b expected 0", bus.in_ready); end
    for (int c = 0; c < 20 && rcvd < 4; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      if (sent < 4) begin
        bus.a = pa[sent];
        bus.b = pb[sent];
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      ir = bus.in_ready;
      ov = bus.out_valid;
      oe = bus.out_exp;
      os = bus.out_man_small;
      @(posedge clk);
      if (ir && sent < 4) sent++;
      if (ov) begin
        checks++; if (oe !== ee[rcvd] || os !== es[rcvd]) begin errors++; $display("FAIL bp_result%0d: got exp %0d small %h expected %0d %h", rcvd, oe, os, ee[rcvd], es[rcvd]); end
        rcvd++;
      end
    end
    #1 bus.in_valid = 1'b0;
    checks++; if (rcvd !== 4 || sent !== 4) begin errors++; $display("FAIL bp_count: got sent %0d received %0d expected 4 4", sent, rcvd); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_duplicate: got out_valid %b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_midstream;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.a = 32'h3F800000; bus.b = 32'h3F800000; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.a = 32'h4B800000; bus.b = 32'h3F800001;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_full: got valid %b in_ready %b expected 1 0", bus.out_valid, bus.in_ready); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_exp !== 8'd0 || bus.out_man_big !== 27'd0 || bus.out_man_small !== 27'd0 || bus.out_sign_big !== 1'b0) begin errors++; $display("FAIL rstmid_data: got exp %h big %h small %h expected all 0", bus.out_exp, bus.out_man_big, bus.out_man_small); end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", bus.in_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale%0d: got out_valid %b expected 0", c, bus.out_valid); end
    end
    send_one(32'h40000000, 32'h3F800000);
    checks++; if (cap_got !== 1'b1 || cap_lat !== 2) begin errors++; $display("FAIL rstmid_next_latency: got got %b lat %0d expected 1 2", cap_got, cap_lat); end
    checks++; if (cap_exp !== 8'd128 || cap_man_small !== 27'h2000000) begin errors++; $display("FAIL rstmid_next_data: got exp %0d small %h expected 128 2000000", cap_exp, cap_man_small); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk           = 1'b0;
    rst           = 1'b1;
    checks        = 0;
    errors        = 0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    test_reset;
    test_equal;
    test_swap_shift;
    test_sticky;
    test_denormal_special;
    test_backpressure;
    test_reset_midstream;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_align_stage.md
Name: fp_align_stage

Overview:
- Two-stage pipelined operand unpack and alignment stage for the single-precision FP adder.
- Sits directly downstream of the exponent field extraction (bits 30:23).
- Unpacks both operands, orders them by magnitude, computes the exponent difference, and right-shifts the smaller significand with guard/round/sticky bits.
- Feeds the add/subtract-and-normalise stage through a valid/ready handshake.

Parameters:
- EXP_W, 8, exponent field width (field occupies bits 30:23).
- MAN_W, 23, stored fraction width (bits 22:0).
- WIDTH, 32, operand width: 1 + EXP_W + MAN_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage can accept operand pair this cycle.
- a  in  WIDTH  operand A, IEEE-754 single.
- b  in  WIDTH  operand B, IEEE-754 single.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts result.
- out_sign_big  out  1  sign of larger-magnitude operand.
- out_sign_small  out  1  sign of smaller-magnitude operand.
- out_exp  out  EXP_W  effective exponent of larger operand.
- out_man_big  out  MAN_W+4  {hidden, fraction, 3'b000}.
- out_man_small  out  MAN_W+4  aligned smaller significand; bits 2:0 are guard, round, sticky.
- out_swap  out  1  1 = B was larger (operands swapped).
- out_special  out  1  either operand has exponent all-ones (Inf/NaN).

Behaviour:
- Reset (async, rst=1): all valid flags 0 and all data registers 0. Therefore out_valid=0 and every out_* =0 while rst is high. in_ready=1 after reset.
- Reset mid-operation discards all in-flight data; no output is produced for it.
- Latency: exactly 2 cycles from accepted input (in_valid & in_ready at edge N) to out_valid at edge N+2, when no backpressure applies.
- Throughput: 1 pair per cycle.
- Handshake rules:
  - Transfer occurs on a rising edge where valid & ready.
  - Stage k advances when its successor is empty or advancing.
  - in_ready = !s1_valid | s2_advance, where s2_advance = !s2_valid | out_ready. in_ready is combinational from out_ready.
  - While out_valid=1 and out_ready=0, all out_* hold stable.
  - Inputs are ignored when in_ready=0.
- Stage 1 (unpack/compare, registered):
  - hidden = (exp != 0). Effective exponent = exp if exp != 0, else 1 (denormal).
  - Significand = {hidden, frac}.
  - Magnitude compare on {eff_exp, sig}. If B > A then swap=1. Ties give swap=0.
  - diff = eff_exp_big - eff_exp_small, unsigned, EXP_W bits; never negative.
  - special = (a.exp == all-ones) | (b.exp == all-ones).
- Stage 2 (align, registered):
  - man_big = {sig_big, 3'b000}.
  - ext = {sig_small, 3'b000}; shifted = ext >> diff.
  - sticky = OR of all bits shifted out, ORed into bit 0 of the result.
  - diff >= MAN_W+4 (27): shifted = 0 and bit0 = |sig_small.
  - diff = 0: man_small = ext unchanged.
  - Both operands zero: all significands 0, exp = 1, swap = 0.
- Signs, exp, swap and special pass through stage 2 unchanged.
- No state machine beyond the two valid flags; each stage is either empty or full.

Test Plan:
- Equal operands: a=0x3F800000, b=0x3F800000 -> 2 cycles later out_exp=127, out_man_big=0x4000000, out_man_small=0x4000000, swap=0, special=0.
- Swap and shift: a=0x3F000000 (0.5), b=0x40000000 (2.0) -> out_swap=1, out_exp=128, out_man_big=0x4000000, out_man_small=0x1000000.
- Sticky: a=0x4B800000, b=0x3F800001 (diff 24) -> out_man_small=0x5 (0x4 plus sticky), out_exp=151. A second case with diff>=27: a=0x4F800000, b=0x3F800000 -> out_man_small=0x1.
- Denormal and special:
  - a=0x00000001, b=0x00800000 -> swap=1, out_exp=1, out_man_small=0x8 (diff 0).
  - a=0x7F800000 -> out_special=1.
- Backpressure: stream 4 pairs back to back with out_ready=0 for cycles 2-5.
  - in_ready must drop after 2 pairs are held.
  - Outputs must stay stable while stalled.
  - All 4 results emerge in order with no loss or duplication once out_ready=1.
- Reset mid-stream: assert rst while both stages are full -> out_valid=0 and out_*=0 immediately (asynchronously). After release, in_ready=1 and the next pair appears after 2 cycles with no stale output.
